// File: rtl/apb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// apb_rr_arbiter
//
// Round-robin arbiter that lets NREQ local requesters share a single APB
// master port. A granted request is driven through the APB SETUP and ACCESS
// phases. Its completion goes back to the requester as a one-cycle req_done
// pulse, together with read data and error status.
//
// Optional feature (compile-time macro):
//   APB_ARB_TIMEOUT_EN - bounds the ACCESS phase to TO_CYCLES wait states.
//                        An expired transfer completes with rsp_slverr = 1.
//
// Ports:
//   pclk, preset        clock and synchronous active-high reset
//   req_valid[NREQ]     per-requester request pending
//   req_write[NREQ]     per-requester direction (1 = write)
//   req_addr/wdata/strb/prot
//                       per-requester fields, requester i at [i*W +: W]
//   req_done[NREQ]      one-hot completion pulse
//   rsp_rdata, rsp_slverr
//                       response, valid while req_done is high
//   psel, penable, pwrite, pprot, paddr, pwdata, pstrb
//                       APB master outputs, all registered
//   pready, pslverr, prdata
//                       APB slave response
// -----------------------------------------------------------------------------
module apb_rr_arbiter #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter int unsigned PROT_W    = 3,
  parameter int unsigned PSTRB_W   = 4,
  parameter int unsigned TO_CYCLES = 16
) (
  input  logic                    pclk,
  input  logic                    preset,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ-1:0]         req_write,
  input  logic [NREQ*AW-1:0]      req_addr,
  input  logic [NREQ*DW-1:0]      req_wdata,
  input  logic [NREQ*PSTRB_W-1:0] req_strb,
  input  logic [NREQ*PROT_W-1:0]  req_prot,
  output logic [NREQ-1:0]         req_done,
  output logic [DW-1:0]           rsp_rdata,
  output logic                    rsp_slverr,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [PROT_W-1:0]       pprot,
  output logic [AW-1:0]           paddr,
  output logic [DW-1:0]           pwdata,
  output logic [PSTRB_W-1:0]      pstrb,
  input  logic                    pready,
  input  logic                    pslverr,
  input  logic [DW-1:0]           prdata
);

  localparam int unsigned GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_e;

  state_e state_q, state_d;

  logic [GW-1:0]      ptr_q, ptr_d;
  logic [GW-1:0]      grant_q, grant_d;
  logic               psel_q, psel_d;
  logic               penable_q, penable_d;
  logic               pwrite_q, pwrite_d;
  logic [PROT_W-1:0]  pprot_q, pprot_d;
  logic [AW-1:0]      paddr_q, paddr_d;
  logic [DW-1:0]      pwdata_q, pwdata_d;
  logic [PSTRB_W-1:0] pstrb_q, pstrb_d;
  logic [NREQ-1:0]    req_done_q, req_done_d;
  logic [DW-1:0]      rsp_rdata_q, rsp_rdata_d;
  logic               rsp_slverr_q, rsp_slverr_d;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TO_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
`else
  logic unused_to_cycles;
  assign unused_to_cycles = (TO_CYCLES == 0);
`endif

  // Unpacked views of the flattened requester buses.
  logic [AW-1:0]      addr_a  [NREQ];
  logic [DW-1:0]      wdata_a [NREQ];
  logic [PSTRB_W-1:0] strb_a  [NREQ];
  logic [PROT_W-1:0]  prot_a  [NREQ];

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      addr_a[i]  = req_addr[i*AW +: AW];
      wdata_a[i] = req_wdata[i*DW +: DW];
      strb_a[i]  = req_strb[i*PSTRB_W +: PSTRB_W];
      prot_a[i]  = req_prot[i*PROT_W +: PROT_W];
    end
  end

  // Round-robin pick: first eligible requester at or above ptr, wrapping.
  // A requester still seeing its own req_done pulse is masked, so a held
  // req_valid is not mistaken for a fresh request in the completion cycle.
  logic [NREQ-1:0] elig;
  logic            found;
  logic [GW-1:0]   pick;
  logic [GW-1:0]   cand;
  int unsigned     idx;

  always_comb begin
    elig  = req_valid & ~req_done_q;
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    idx   = 0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      idx  = (32'(ptr_q) + off) % NREQ;
      cand = GW'(idx);
      if (!found && elig[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    grant_d      = grant_q;
    psel_d       = psel_q;
    penable_d    = penable_q;
    pwrite_d     = pwrite_q;
    pprot_d      = pprot_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    pstrb_d      = pstrb_q;
    req_done_d   = '0;
    rsp_rdata_d  = '0;
    rsp_slverr_d = 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d  = pick;
          psel_d   = 1'b1;
          pwrite_d = req_write[pick];
          paddr_d  = addr_a[pick];
          pwdata_d = wdata_a[pick];
          pstrb_d  = strb_a[pick];
          pprot_d  = prot_a[pick];
          state_d  = SETUP;
        end
      end

      SETUP: begin
        penable_d = 1'b1;
`ifdef APB_ARB_TIMEOUT_EN
        cnt_d     = '0;
`endif
        state_d   = ACCESS;
      end

      ACCESS: begin
        if (pready) begin
          psel_d              = 1'b0;
          penable_d           = 1'b0;
          req_done_d[grant_q] = 1'b1;
          rsp_slverr_d        = pslverr;
          rsp_rdata_d         = pwrite_q ? '0 : prdata;
          ptr_d               = (grant_q == GW'(NREQ - 1)) ? '0 : grant_q + 1'b1;
          state_d             = IDLE;
        end
`ifdef APB_ARB_TIMEOUT_EN
        // Terminate in the wait cycle that brings the count to TO_CYCLES,
        // so the transfer sees exactly TO_CYCLES wait states.
        else if (cnt_q == CW'(TO_CYCLES - 1)) begin
          psel_d              = 1'b0;
          penable_d           = 1'b0;
          req_done_d[grant_q] = 1'b1;
          rsp_slverr_d        = 1'b1;
          rsp_rdata_d         = '0;
          ptr_d               = (grant_q == GW'(NREQ - 1)) ? '0 : grant_q + 1'b1;
          state_d             = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end

      default: begin
        state_d   = IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      grant_q      <= '0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      pprot_q      <= '0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      pstrb_q      <= '0;
      req_done_q   <= '0;
      rsp_rdata_q  <= '0;
      rsp_slverr_q <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      grant_q      <= grant_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      pwrite_q     <= pwrite_d;
      pprot_q      <= pprot_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      pstrb_q      <= pstrb_d;
      req_done_q   <= req_done_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_slverr_q <= rsp_slverr_d;
`ifdef APB_ARB_TIMEOUT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign psel       = psel_q;
  assign penable    = penable_q;
  assign pwrite     = pwrite_q;
  assign pprot      = pprot_q;
  assign paddr      = paddr_q;
  assign pwdata     = pwdata_q;
  assign pstrb      = pstrb_q;
  assign req_done   = req_done_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_slverr = rsp_slverr_q;

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_apb_rr_arbiter
//
// Directed self-checking bench for apb_rr_arbiter (NREQ = 4, 32-bit buses).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// "Cycle n" means the sample point n edges after stimulus was applied.
// Honours APB_ARB_TIMEOUT_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_apb_rr_arbiter;

  localparam int NREQ = 4, AW = 32, DW = 32, PROT_W = 3, PSTRB_W = 4, TO_CYCLES = 16;

  logic                    pclk = 1'b0;
  logic                    preset;
  logic [NREQ-1:0]         req_valid, req_write, req_done;
  logic [NREQ*AW-1:0]      req_addr;
  logic [NREQ*DW-1:0]      req_wdata;
  logic [NREQ*PSTRB_W-1:0] req_strb;
  logic [NREQ*PROT_W-1:0]  req_prot;
  logic [DW-1:0]           rsp_rdata, pwdata, prdata;
  logic                    rsp_slverr, psel, penable, pwrite, pready, pslverr;
  logic [PROT_W-1:0]       pprot;
  logic [AW-1:0]           paddr;
  logic [PSTRB_W-1:0]      pstrb;

  int n_checks = 0;
  int n_fail   = 0;

  apb_rr_arbiter #(
    .NREQ(NREQ), .AW(AW), .DW(DW), .PROT_W(PROT_W), .PSTRB_W(PSTRB_W), .TO_CYCLES(TO_CYCLES)
  ) dut (
    .pclk(pclk), .preset(preset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_strb(req_strb), .req_prot(req_prot),
    .req_done(req_done), .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr),
    .psel(psel), .penable(penable), .pwrite(pwrite), .pprot(pprot),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready), .pslverr(pslverr), .prdata(prdata)
  );

  always #5 pclk = ~pclk;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic clear_inputs();
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    req_strb = '0; req_prot = '0; pready = 1'b1; pslverr = 1'b0; prdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    preset = 1'b1;
    tick();
    tick();
    preset = 1'b0;
  endtask

  task automatic set_req(input int i, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s, input logic [2:0] p);
    req_write[i]            = wr;
    req_addr[i*AW +: AW]    = a;
    req_wdata[i*DW +: DW]   = d;
    req_strb[i*4 +: 4]      = s;
    req_prot[i*3 +: 3]      = p;
    req_valid[i]            = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    req_valid = '1;
    preset = 1'b1;
    tick();
    tick();
    n_checks++; if (psel !== 1'b0) begin n_fail++; $display("FAIL rst_psel: got %b want 0", psel); end
    n_checks++; if (penable !== 1'b0) begin n_fail++; $display("FAIL rst_penable: got %b want 0", penable); end
    n_checks++; if (pwrite !== 1'b0) begin n_fail++; $display("FAIL rst_pwrite: got %b want 0", pwrite); end
    n_checks++; if (paddr !== 32'h0) begin n_fail++; $display("FAIL rst_paddr: got %h want 0", paddr); end
    n_checks++; if (pwdata !== 32'h0) begin n_fail++; $display("FAIL rst_pwdata: got %h want 0", pwdata); end
    n_checks++; if (pstrb !== 4'h0) begin n_fail++; $display("FAIL rst_pstrb: got %h want 0", pstrb); end
    n_checks++; if (pprot !== 3'h0) begin n_fail++; $display("FAIL rst_pprot: got %h want 0", pprot); end
    n_checks++; if (req_done !== 4'h0) begin n_fail++; $display("FAIL rst_done: got %b want 0000", req_done); end
    n_checks++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", rsp_rdata); end
    n_checks++; if (rsp_slverr !== 1'b0) begin n_fail++; $display("FAIL rst_slverr: got %b want 0", rsp_slverr); end
    preset = 1'b0;
    req_valid = '0;
    tick();
    n_checks++; if (psel !== 1'b0) begin n_fail++; $display("FAIL rst_idle_psel: got %b want 0", psel); end
  endtask

  task automatic test_single_read();
    do_reset();
    set_req(2, 1'b0, 32'h40, 32'h0, 4'h0, 3'h0);
    prdata = 32'hCAFEF00D;
    tick();
    n_checks++; if (psel !== 1'b1) begin n_fail++; $display("FAIL rd_c1_psel: got %b want 1", psel); end
    n_checks++; if (penable !== 1'b0) begin n_fail++; $display("FAIL rd_c1_penable: got %b want 0", penable); end
    n_checks++; if (paddr !== 32'h40) begin n_fail++; $display("FAIL rd_c1_paddr: got %h want 40", paddr); end
    n_checks++; if (pwrite !== 1'b0) begin n_fail++; $display("FAIL rd_c1_pwrite: got %b want 0", pwrite); end
    tick();
    n_checks++; if ({psel, penable} !== 2'b11) begin n_fail++; $display("FAIL rd_c2_sel_en: got %b want 11", {psel, penable}); end
    n_checks++; if (req_done !== 4'b0000) begin n_fail++; $display("FAIL rd_c2_done: got %b want 0000", req_done); end
    tick();
    n_checks++; if (req_done !== 4'b0100) begin n_fail++; $display("FAIL rd_c3_done: got %b want 0100", req_done); end
    n_checks++; if (rsp_rdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL rd_c3_rdata: got %h want cafef00d", rsp_rdata); end
    n_checks++; if (rsp_slverr !== 1'b0) begin n_fail++; $display("FAIL rd_c3_slverr: got %b want 0", rsp_slverr); end
    n_checks++; if ({psel, penable} !== 2'b00) begin n_fail++; $display("FAIL rd_c3_sel_en: got %b want 00", {psel, penable}); end
    req_valid[2] = 1'b0;
    tick();
    n_checks++; if (req_done !== 4'b0000) begin n_fail++; $display("FAIL rd_c4_done: got %b want 0000", req_done); end
    n_checks++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL rd_c4_rdata: got %h want 0", rsp_rdata); end
    n_checks++; if (paddr !== 32'h40) begin n_fail++; $display("FAIL rd_c4_paddr_hold: got %h want 40", paddr); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_done;
    do_reset();
    for (int i = 0; i < 4; i++)
      set_req(i, 1'b1, 32'h100 + 32'(i * 4), 32'hA000_0000 + 32'(i), 4'hF, 3'(i));
    for (int k = 0; k < 5; k++) begin
      int g;
      g = k % 4;
      exp_done = 4'(1 << g);
      tick();
      n_checks++; if ({psel, penable} !== 2'b10) begin n_fail++; $display("FAIL b2b_setup k=%0d: got %b want 10", k, {psel, penable}); end
      n_checks++; if (paddr !== 32'h100 + 32'(g * 4)) begin n_fail++; $display("FAIL b2b_paddr k=%0d: got %h want %h", k, paddr, 32'h100 + 32'(g * 4)); end
      n_checks++; if (pwdata !== 32'hA000_0000 + 32'(g)) begin n_fail++; $display("FAIL b2b_pwdata k=%0d: got %h want %h", k, pwdata, 32'hA000_0000 + 32'(g)); end
      n_checks++; if (pprot !== 3'(g)) begin n_fail++; $display("FAIL b2b_pprot k=%0d: got %h want %h", k, pprot, 3'(g)); end
      tick();
      n_checks++; if (penable !== 1'b1) begin n_fail++; $display("FAIL b2b_access k=%0d: got %b want 1", k, penable); end
      tick();
      n_checks++; if (psel !== 1'b0) begin n_fail++; $display("FAIL b2b_gap k=%0d: got %b want 0", k, psel); end
      n_checks++; if (req_done !== exp_done) begin n_fail++; $display("FAIL b2b_done k=%0d: got %b want %b", k, req_done, exp_done); end
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_wait_states();
    do_reset();
    set_req(1, 1'b1, 32'h2000_0010, 32'h1234_5678, 4'b0011, 3'b010);
    prdata = 32'hDEADBEEF;
    tick();
    n_checks++; if ({psel, pwrite, pstrb, pprot} !== {1'b1, 1'b1, 4'b0011, 3'b010}) begin n_fail++; $display("FAIL ws_setup: got %b want 11 0011 010", {psel, pwrite, pstrb, pprot}); end
    tick();
    n_checks++; if (penable !== 1'b1) begin n_fail++; $display("FAIL ws_c2_penable: got %b want 1", penable); end
    pready = 1'b0;
    req_addr[1*AW +: AW]  = 32'hFFFF_0000;
    req_wdata[1*DW +: DW] = 32'h0BAD_0BAD;
    for (int w = 0; w < 3; w++) begin
      tick();
      n_checks++; if ({psel, penable} !== 2'b11) begin n_fail++; $display("FAIL ws_hold w=%0d: got %b want 11", w, {psel, penable}); end
      n_checks++; if (paddr !== 32'h2000_0010) begin n_fail++; $display("FAIL ws_paddr w=%0d: got %h want 20000010", w, paddr); end
      n_checks++; if (pwdata !== 32'h1234_5678) begin n_fail++; $display("FAIL ws_pwdata w=%0d: got %h want 12345678", w, pwdata); end
      n_checks++; if (req_done !== 4'b0000) begin n_fail++; $display("FAIL ws_early_done w=%0d: got %b want 0000", w, req_done); end
    end
    pready  = 1'b1;
    pslverr = 1'b1;
    tick();
    n_checks++; if (req_done !== 4'b0010) begin n_fail++; $display("FAIL ws_done: got %b want 0010", req_done); end
    n_checks++; if (rsp_slverr !== 1'b1) begin n_fail++; $display("FAIL ws_slverr: got %b want 1", rsp_slverr); end
    n_checks++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL ws_rdata: got %h want 0", rsp_rdata); end
    n_checks++; if (penable !== 1'b0) begin n_fail++; $display("FAIL ws_penable_end: got %b want 0", penable); end
    req_valid = '0;
    pslverr = 1'b0;
    tick();
  endtask

  task automatic test_same_requester();
    do_reset();
    set_req(3, 1'b0, 32'h30, 32'h0, 4'h0, 3'h0);
    prdata = 32'h1111_2222;
    tick();
    tick();
    tick();
    n_checks++; if (req_done !== 4'b1000) begin n_fail++; $display("FAIL same_done1: got %b want 1000", req_done); end
    req_addr[3*AW +: AW] = 32'h34;
    prdata = 32'h3333_4444;
    tick();
    n_checks++; if (psel !== 1'b0) begin n_fail++; $display("FAIL same_no_regrant: got %b want 0", psel); end
    tick();
    n_checks++; if (psel !== 1'b1) begin n_fail++; $display("FAIL same_regrant: got %b want 1", psel); end
    n_checks++; if (paddr !== 32'h34) begin n_fail++; $display("FAIL same_paddr2: got %h want 34", paddr); end
    tick();
    tick();
    n_checks++; if (req_done !== 4'b1000) begin n_fail++; $display("FAIL same_done2: got %b want 1000", req_done); end
    n_checks++; if (rsp_rdata !== 32'h3333_4444) begin n_fail++; $display("FAIL same_rdata2: got %h want 33334444", rsp_rdata); end
    req_valid = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    // Complete one transfer from requester 0 so ptr moves to 1.
    set_req(0, 1'b0, 32'h0, 32'h0, 4'h0, 3'h0);
    tick(); tick(); tick();
    req_valid = '0;
    tick();
    set_req(2, 1'b0, 32'h80, 32'h0, 4'h0, 3'h0);
    pready = 1'b0;
    tick(); tick(); tick();
    n_checks++; if ({psel, penable} !== 2'b11) begin n_fail++; $display("FAIL rm_in_access: got %b want 11", {psel, penable}); end
    preset = 1'b1;
    pready = 1'b1;
    tick();
    n_checks++; if ({psel, penable} !== 2'b00) begin n_fail++; $display("FAIL rm_sel_en: got %b want 00", {psel, penable}); end
    n_checks++; if (req_done !== 4'b0000) begin n_fail++; $display("FAIL rm_no_done: got %b want 0000", req_done); end
    preset = 1'b0;
    req_valid = '0;
    set_req(0, 1'b0, 32'h1000, 32'h0, 4'h0, 3'h0);
    set_req(3, 1'b0, 32'h3000, 32'h0, 4'h0, 3'h0);
    tick();
    n_checks++; if (psel !== 1'b1) begin n_fail++; $display("FAIL rm_regrant_psel: got %b want 1", psel); end
    n_checks++; if (paddr !== 32'h1000) begin n_fail++; $display("FAIL rm_grant0_paddr: got %h want 1000", paddr); end
    tick();
    tick();
    n_checks++; if (req_done !== 4'b0001) begin n_fail++; $display("FAIL rm_done0: got %b want 0001", req_done); end
    req_valid = '0;
    tick();
  endtask

  task automatic test_timeout();
    int bad;
    do_reset();
    set_req(0, 1'b0, 32'h50, 32'h0, 4'h0, 3'h0);
    prdata = 32'hBAD0_BAD0;
    pready = 1'b0;
    tick();
    tick();
    bad = 0;
`ifdef APB_ARB_TIMEOUT_EN
    if (req_done !== 4'b0000) bad++;
    for (int c = 3; c <= 17; c++) begin
      tick();
      if (req_done !== 4'b0000) bad++;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL to_early_done: got %0d early cycles want 0", bad); end
    tick();
    n_checks++; if (req_done !== 4'b0001) begin n_fail++; $display("FAIL to_done: got %b want 0001", req_done); end
    n_checks++; if (rsp_slverr !== 1'b1) begin n_fail++; $display("FAIL to_slverr: got %b want 1", rsp_slverr); end
    n_checks++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL to_rdata: got %h want 0", rsp_rdata); end
    n_checks++; if ({psel, penable} !== 2'b00) begin n_fail++; $display("FAIL to_sel_en: got %b want 00", {psel, penable}); end
`else
    for (int c = 0; c < 100; c++) begin
      tick();
      if (req_done !== 4'b0000) bad++;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL nto_done: got %0d completion cycles want 0", bad); end
    n_checks++; if ({psel, penable} !== 2'b11) begin n_fail++; $display("FAIL nto_still_access: got %b want 11", {psel, penable}); end
`endif
    do_reset();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_back_to_back();
    test_wait_states();
    test_same_requester();
    test_reset_mid();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
